gauss_read_scheduler: RTL
=========================

# gauss_read_scheduler

Sequences SRAM read traffic and datapath enables for the 5x5 Gaussian smoothing pipeline, replacing the behavioural address generator and one-shot enable pulses currently driven from the bench. For every image column word it issues five reads, one per window row, spaced one row stride apart. It then steers the returned 64-bit words into the row buffer block and the shifter block, and fires the hold/multiplier/normaliser start and output-writer start pulses at the correct cycles. A start/busy/done handshake lets a top-level frame controller run it once per frame.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width.
- ROW_WORDS, 256, 64-bit words per image row (row stride).
- START_ADDR, 1024, column address of the bottom window row for the first column.
- END_ADDR, 523518, column address of the bottom window row for the last column (inclusive).
- PUT_DLY, 15, cycles from the first shift_load to out_start.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle frame start request.
- pause  in  1  downstream back-pressure, checked at column boundaries only.
- rd_addr  out  ADDR_W  SRAM read address.
- rd_en  out  1  read issued this cycle.
- buf_pop  out  1  to the buffer block: q holds a row 0..3 word this cycle.
- shift_load  out  1  to the shifter block: q holds the row-4 word; load all five rows.
- pipe_start  out  1  one pulse for the hold, multiplier and normaliser enables.
- out_start  out  1  one pulse for the normalised-output writer enable.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 -> ISSUE.
  - col <= START_ADDR, phase <= 0.
- ISSUE: each cycle, rd_en=1 and rd_addr = col - phase*ROW_WORDS.
  - Arithmetic is modulo 2^ADDR_W; wrap below 0 is not flagged.
  - phase 0..3 -> phase+1.
  - phase 4 -> phase 0 and col+1.
  - If phase 4 is issued with col==END_ADDR -> DRAIN.
- Pause: sampled only when the next issue would be phase 0.
  - pause=1 holds rd_en=0 and freezes col and phase.
  - pause during phases 1..4 is ignored, so a 5-word group is never split.
- Return path: SRAM read latency is exactly 1 cycle.
  - Registered copies v_d = rd_en and ph_d = phase.
  - buf_pop = v_d & (ph_d<4).
  - shift_load = v_d & (ph_d==4).
- pipe_start pulses once per frame, coincident with the first shift_load.
- out_start: a counter started by the first shift_load pulses out_start exactly PUT_DLY cycles later.
  - The counter ignores pause.
  - If the frame ends first, the counter still completes and out_start still fires, while in DRAIN/DONE.
  - DONE is left only after out_start has fired.
- DRAIN: lasts one cycle (the last shift_load), then -> DONE.
- DONE: done=1 for one cycle, busy=0 that cycle, then -> IDLE.
- start while busy is ignored; start coincident with done is ignored.
- Reset (any state) -> IDLE with every output 0, rd_addr=0, and counters and return-path registers cleared.
  - In-flight read data is discarded: no buf_pop or shift_load after reset.

## Timing
- start sampled high at edge T.
- busy=1 from T+1 until the done cycle.
- Column k, phase p issues rd_en at T+1+5k+p (no pause).
- buf_pop at T+2+5k+p for p=0..3; shift_load at T+6+5k.
- pipe_start at T+6.
- out_start at T+6+PUT_DLY.
- Last column N-1, where N = END_ADDR-START_ADDR+1:
  - last shift_load at T+1+5N.
  - done at max(T+2+5N, T+7+PUT_DLY).
- Each pause cycle at a column boundary delays all later read and return events by one cycle.
- rd_en/rd_addr, buf_pop and shift_load are registered outputs.

## Test plan
- ROW_WORDS=4, START_ADDR=16, END_ADDR=18, PUT_DLY=3, start at T -> rd_addr sequence 16,12,8,4,0,17,13,9,5,1,18,14,10,6,2 on consecutive cycles; 12 buf_pop and 3 shift_load (T+6, T+11, T+16); pipe_start at T+6; out_start at T+9; done at T+17.
- Same config with pause=1 for 2 cycles when phase 0 of column 17 is due, plus pause=1 during phase 2 of column 16 -> phase-2 pause has no effect; two idle rd_en=0 cycles before address 17; done at T+19.
- START_ADDR=2, ROW_WORDS=4, END_ADDR=2 -> rd_addr 2, 0xFFFFE, 0xFFFFA, 0xFFFF6, 0xFFFF2; single shift_load; out_start still fires before done.
- Reset asserted during phase 3 of column 17 -> next cycle all outputs 0 and state IDLE; no buf_pop or shift_load for the in-flight read; new start behaves like the first scenario.
- start pulsed during ISSUE and on the done cycle -> ignored, no restart; a start one cycle after done begins a new frame at START_ADDR.
- Default parameters, full frame -> 5*522495 reads, last rd_addr 523518-1024=522494, done follows the last shift_load by one cycle.

Source files
------------

// File: rtl/gauss_read_scheduler.sv
// Read sequencer for the 5x5 Gaussian pipeline: five row reads per column word,
// return-path steering into buffer/shifter, and one-shot pipeline start pulses.
module gauss_read_scheduler #(
  parameter int ADDR_W     = 20,
  parameter int ROW_WORDS  = 256,
  parameter int START_ADDR = 1024,
  parameter int END_ADDR   = 523518,
  parameter int PUT_DLY    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              buf_pop,
  output logic              shift_load,
  output logic              pipe_start,
  output logic              out_start,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int                CNT_W     = $clog2(PUT_DLY + 1);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] FIRST_COL = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] PAST_COL  = ADDR_W'(END_ADDR + 1);
  localparam logic [CNT_W-1:0]  PUT_CNT   = CNT_W'(PUT_DLY);

  state_t            state, stateNext;
  logic [ADDR_W-1:0] col;
  logic [2:0]        phase;
  logic [2:0]        rdPhase;
  logic              vD;
  logic [2:0]        phD;
  logic              pipeFired, outFired, cntRun;
  logic [CNT_W-1:0]  cnt;
  logic              lastVisible, issueNow;

  // The final phase-4 read is on the bus this cycle; col has already moved past the end.
  assign lastVisible = rd_en && (rdPhase == 3'd4) && (col == PAST_COL);

  // Pause is honoured only before a phase-0 read, so a 5-word group is never split.
  assign issueNow = ((state == IDLE && start) || (state == ISSUE && !lastVisible)) &&
                    (phase != 3'd0 || !pause);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // NOTE: every variable assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (start)       stateNext = ISSUE;
      ISSUE: if (lastVisible) stateNext = DRAIN;
      DRAIN:                  stateNext = DONE;
      DONE:  if (outFired)    stateNext = IDLE;
      default:                stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ISSUE, DRAIN: busy = 1'b1;
      DONE: begin
        busy = !outFired;
        done = outFired;
      end
      default: ;
    endcase
  end

  // Issue side: address generation and registered read request.
  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= FIRST_COL;
      phase   <= 3'd0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rdPhase <= 3'd0;
    end else begin
      rd_en <= issueNow;
      if (issueNow) begin
        rd_addr <= col - STRIDE * ADDR_W'(phase);
        rdPhase <= phase;
        if (phase == 3'd4) begin
          phase <= 3'd0;
          col   <= col + ADDR_W'(1);
        end else begin
          phase <= phase + 3'd1;
        end
      end else if (state != ISSUE) begin
        col   <= FIRST_COL;
        phase <= 3'd0;
      end
    end
  end

  // Return path: SRAM data arrives one cycle after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      vD  <= 1'b0;
      phD <= 3'd0;
    end else begin
      vD  <= rd_en;
      phD <= rdPhase;
    end
  end

  assign buf_pop    = vD && (phD < 3'd4);
  assign shift_load = vD && (phD == 3'd4);
  assign pipe_start = shift_load && !pipeFired;
  assign out_start  = cntRun && (cnt == PUT_CNT);

  // Output-writer delay counter runs independently of pause and frame end.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      pipeFired <= 1'b0;
      outFired  <= 1'b0;
      cntRun    <= 1'b0;
      cnt       <= '0;
    end else if (pipe_start) begin
      pipeFired <= 1'b1;
      cntRun    <= 1'b1;
      cnt       <= CNT_W'(1);
    end else if (cntRun) begin
      if (out_start) begin
        cntRun   <= 1'b0;
        outFired <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
